// File: rtl/imm_extend_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_extend_stage_if                                             |
// | Brief    : Valid/ready bus between decode, immediate extension and ID/EX.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface imm_extend_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       mode_i;
  logic [IN_W-1:0]  data_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;
  logic [1:0]       mode_o;

  modport master (
    output valid_i, mode_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, mode_o
  );

  modport slave (
    input  valid_i, mode_i, data_i, ready_i,
    output ready_o, valid_o, data_o, mode_o
  );
endinterface
`default_nettype wire

// File: rtl/imm_extend_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : imm_extend_stage                                                |
// | Brief    : Registered sign/zero/upper immediate extension, 2-entry skid.   |
// |            IMM_EXT_BRANCH_EN makes mode 11 a branch offset (sext << 2).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         flush_i,
  imm_extend_stage_if.slave bus
);
  localparam int c_PAD_W = OUT_W - IN_W;

  logic             r_main_valid;
  logic [OUT_W-1:0] r_main_data;
  logic [1:0]       r_main_mode;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [1:0]       r_skid_mode;

  logic             w_accept;
  logic             w_drain;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;

  assign bus.ready_o = rst_i & ~r_skid_valid;
  assign w_accept    = bus.valid_i & bus.ready_o;
  assign w_drain     = r_main_valid & bus.ready_i;

  assign bus.valid_o = r_main_valid;
  assign bus.data_o  = r_main_data;
  assign bus.mode_o  = r_main_mode;

  // Entries are stored already extended so the output is a pure register.
  always_comb begin
    w_sext = {{c_PAD_W{bus.data_i[IN_W-1]}}, bus.data_i};
    w_ext  = w_sext;
    case (bus.mode_i)
      2'b01: w_ext = {{c_PAD_W{1'b0}}, bus.data_i};
      2'b10: w_ext = {bus.data_i, {c_PAD_W{1'b0}}};
      2'b11: begin
`ifdef IMM_EXT_BRANCH_EN
        w_ext = w_sext << 2;
`else
        w_ext = w_sext;
`endif
      end
      default: w_ext = w_sext;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_mode  <= 2'b00;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_mode  <= 2'b00;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || w_drain) begin
      if (r_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= r_skid_data;
        r_main_mode  <= r_skid_mode;
        r_skid_valid <= w_accept;
        if (w_accept) begin
          r_skid_data <= w_ext;
          r_skid_mode <= bus.mode_i;
        end
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) begin
          r_main_data <= w_ext;
          r_main_mode <= bus.mode_i;
        end
      end
    end else if (w_accept) begin
      // Main is stalled: park the new entry behind it.
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ext;
      r_skid_mode  <= bus.mode_i;
    end
  end
endmodule
`default_nettype wire

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Parametrised, registered immediate-extension stage for the pipelined MIPS datapath, between instruction decode and the ID/EX register.
- Converts an IN_W-bit immediate to OUT_W bits in one of several modes: sign, zero, or upper (LUI-style).
- Valid/ready handshake on both sides, 2-entry skid buffer, 1-cycle latency, and a synchronous flush for branch/jump squash.

Parameters:
- IN_W, 16, immediate input width; legal range 1 to OUT_W-1.
- OUT_W, 32, extended output width; must be greater than IN_W.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-low reset.
- flush_i  input  1  synchronous squash of all buffered entries.
- valid_i  input  1  input immediate valid.
- ready_o  output  1  stage can accept this cycle.
- mode_i  input  2  00 sign, 01 zero, 10 upper, 11 see Optional Feature.
- data_i  input  IN_W  immediate.
- valid_o  output  1  output entry valid.
- ready_i  input  1  downstream accepts.
- data_o  output  OUT_W  extended immediate.
- mode_o  output  2  mode carried with data_o.

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-low.
- Reset (rst_i=0 at an edge): main and skid entries invalid. valid_o=0, data_o=0, mode_o=0.
- ready_o is combinational: rst_i & !skid_valid. It is 0 while reset is asserted.
- Extension is computed at input acceptance and stored already extended:
  - Sign: upper OUT_W-IN_W bits replicate data_i[IN_W-1].
  - Zero: upper bits 0.
  - Upper: data_i in bits [OUT_W-1:OUT_W-IN_W], lower OUT_W-IN_W bits 0.
- Terms: accept = valid_i & ready_o. drain = valid_o & ready_i.
- Latency: an accepted input appears on data_o in the next cycle, provided main is empty or draining.
- Per-edge update, in priority order:
  1. rst_i=0: reset.
  2. flush_i=1: main and skid invalid. Any input accepted this cycle is dropped. data_o holds its last value (don't-care).
  3. Main empty or drain:
     - main <= skid if skid_valid; else main <= input if accept; else main invalid.
     - If skid was loaded into main and accept, the new input goes to skid.
  4. Main valid and !ready_i: if accept, the input goes to skid; main holds.
- Full: skid_valid=1 forces ready_o=0. No entry is ever overwritten or lost.
- Order is preserved (FIFO). Main, skid and mode_o move together.
- While valid_o=1 and ready_i=0, data_o and mode_o are stable.
- Simultaneous accept and drain with skid empty: main <= new input; throughput 1 per cycle.
- Reset or flush in the middle of a stall discards everything. The next accept after deassertion behaves as from empty.
- Throughput: one transfer per cycle sustained while ready_i=1.

Optional Feature:
- Macro: IMM_EXT_BRANCH_EN.
- Defined: mode 11 = branch offset, i.e. sign-extend then shift left by 2, dropping the top 2 bits, low 2 bits 0.
- Not defined: mode 11 behaves exactly as mode 00 (sign). mode_o still reports 11.

Test Plan:
- Reset and basic sign: hold rst_i=0 for 2 cycles, check valid_o=0, data_o=0, ready_o=0. Release, send data_i=16'h8004, mode 00 with ready_i=1 -> next cycle valid_o=1, data_o=32'hFFFF8004.
- Zero and upper modes: data_i=16'h8004 mode 01 -> 32'h00008004. data_i=16'h1234 mode 10 -> 32'h12340000. Both complete back-to-back with one result per cycle.
- Backpressure and skid: ready_i=0, send A=16'h0001 then B=16'h0002 -> ready_o drops to 0 after B. Raise ready_i -> outputs 32'h00000001 then 32'h00000002 in order, no loss, then ready_o=1.
- Flush: buffer two entries under ready_i=0, assert flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1. No flushed or same-cycle data ever appears.
- Mode 11, data_i=16'hFFFF: with IMM_EXT_BRANCH_EN -> 32'hFFFFFFFC. Without -> 32'hFFFFFFFF. mode_o=11 in both builds.
- Parameter sweep IN_W=8, OUT_W=16, data_i=8'h80: mode 00 -> 16'hFF80, 01 -> 16'h0080, 10 -> 16'h8000. Under a random valid/ready/flush soak, the scoreboard shows no reordering, drops or duplicates.
